// File: rtl/wb_timer_slave.sv
// Wishbone classic slave exposing a 32-bit prescaled timer with compare match and level interrupt.
// Bus accesses pass through IDLE -> WAIT -> ACK with a programmable number of wait states.
module wb_timer_slave #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] CMP_RESET   = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        irq_o
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_COUNT  = 2'd1;
    localparam logic [1:0] A_CMP    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        req;
    logic        load_rd;
    logic        bus_wr;

    logic        ctrl_en, ctrl_ar, ctrl_ie;
    logic [15:0] ctrl_ps;
    logic [15:0] pre, pre_nxt;
    logic [31:0] count, count_tmr;
    logic [31:0] compare;
    logic        match;
    logic        tick, hit, w1c;
    logic [31:0] rd_word;
    logic [31:0] rd_dat_p1;

    // Replace only the byte lanes enabled by sel.
    function automatic logic [31:0] lanes(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign req = cyc_i & stb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // Counter holds the wait cycles still to spend, this one included.
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt <= 4'd1) begin
                    state_nxt = S_ACK;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o   = (state == S_ACK);
        load_rd = (state != S_ACK) && (state_nxt == S_ACK);
        bus_wr  = (state == S_ACK) && we_i;
        dat_o   = (state == S_ACK) ? rd_dat_p1 : 32'd0;
    end

    always_comb begin
        case (adr_i)
            A_CTRL:   rd_word = {ctrl_ps, 13'd0, ctrl_ie, ctrl_ar, ctrl_en};
            A_COUNT:  rd_word = count;
            A_CMP:    rd_word = compare;
            A_STATUS: rd_word = {31'd0, match};
            default:  rd_word = 32'd0;
        endcase
    end

    assign tick = ctrl_en && (pre == ctrl_ps);
    assign hit  = tick && (count == compare);
    assign w1c  = bus_wr && (adr_i == A_STATUS) && sel_i[0] && dat_i[0];

    always_comb begin
        count_tmr = count;
        if (tick) count_tmr = (hit && ctrl_ar) ? 32'd0 : count + 32'd1;
        pre_nxt = (ctrl_en && !tick) ? pre + 16'd1 : 16'd0;
    end

    // Read data is captured on entry to ACK, before this edge's own updates land.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en   <= 1'b0;
            ctrl_ar   <= 1'b0;
            ctrl_ie   <= 1'b0;
            ctrl_ps   <= 16'd0;
            pre       <= 16'd0;
            count     <= 32'd0;
            compare   <= CMP_RESET;
            match     <= 1'b0;
            rd_dat_p1 <= 32'd0;
        end else begin
            if (load_rd) rd_dat_p1 <= rd_word;
            pre <= pre_nxt;
            if (bus_wr && adr_i == A_COUNT) begin
                count <= lanes(count, dat_i, sel_i);
            end else begin
                count <= count_tmr;
            end
            if (bus_wr && adr_i == A_CMP) compare <= lanes(compare, dat_i, sel_i);
            if (bus_wr && adr_i == A_CTRL) begin
                if (sel_i[0]) {ctrl_ie, ctrl_ar, ctrl_en} <= dat_i[2:0];
                if (sel_i[2]) ctrl_ps[7:0]  <= dat_i[23:16];
                if (sel_i[3]) ctrl_ps[15:8] <= dat_i[31:24];
            end
            if (hit) begin
                match <= 1'b1;
            end else if (w1c) begin
                match <= 1'b0;
            end
        end
    end

    assign irq_o = match & ctrl_ie;

endmodule
